// File: rtl/lfsr_prbs_gen.sv
// ---------------------------------------------------------------------------------------------
// lfsr_prbs_gen
//   Multi-channel Fibonacci LFSR pseudo-random word generator. Each channel has its own state,
//   valid/ready output handshake, runtime reseed and a wrapping count of accepted words.
//
// Ports
//   CLK        clock, all logic on the rising edge
//   RST_N      synchronous active-low reset
//   I_EN       global enable; channels offer a new word only while set
//   I_SEED_LD  per-channel seed load strobe
//   I_SEED     seed shared by every channel being loaded (zero is replaced by LFSR_DEFAULT)
//   O_VALID    per-channel word-available flag
//   I_READY    per-channel consumer accept; handshake when O_VALID[c] & I_READY[c]
//   O_DATA     channel c word on O_DATA[c*LFSR_DW +: LFSR_DW] (the channel state register)
//   O_CNT      channel c accepted-word count on O_CNT[c*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------------------------
module lfsr_prbs_gen #(
  parameter int unsigned        LFSR_DW      = 8,
  parameter logic [LFSR_DW-1:0] LFSR_TAPS    = 8'hB8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 8'h01,
  parameter int unsigned        NUM_CH       = 2,
  parameter int unsigned        CNT_W        = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      I_EN,
  input  logic [NUM_CH-1:0]         I_SEED_LD,
  input  logic [LFSR_DW-1:0]        I_SEED,
  output logic [NUM_CH-1:0]         O_VALID,
  input  logic [NUM_CH-1:0]         I_READY,
  output logic [NUM_CH*LFSR_DW-1:0] O_DATA,
  output logic [NUM_CH*CNT_W-1:0]   O_CNT
);

  // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
  logic [LFSR_DW-1:0] w_seed;
  assign w_seed = (I_SEED == '0) ? LFSR_DEFAULT : I_SEED;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channels start from the default rotated by their index so they do not run in lockstep.
    localparam int unsigned        ROT      = c % LFSR_DW;
    localparam logic [LFSR_DW-1:0] RST_SEED = (ROT == 0) ? LFSR_DEFAULT :
        ((LFSR_DEFAULT << ROT) | (LFSR_DEFAULT >> (LFSR_DW - ROT)));

    logic [LFSR_DW-1:0] r_state;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_fb;
    logic [LFSR_DW-1:0] w_next;
    logic               w_hs;

    assign w_fb   = ^(r_state & LFSR_TAPS);
    assign w_next = {r_state[LFSR_DW-2:0], w_fb};
    assign w_hs   = r_valid & I_READY[c];

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        r_state <= RST_SEED;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (I_SEED_LD[c]) begin
        // Load flushes any same-cycle handshake: the word is neither counted nor stepped.
        r_state <= w_seed;
        r_valid <= I_EN;
        r_cnt   <= '0;
      end else if (w_hs) begin
        r_state <= w_next;
        r_valid <= I_EN;
        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!r_valid && I_EN) begin
        r_valid <= 1'b1;
      end
    end

    assign O_VALID[c]                     = r_valid;
    assign O_DATA[c*LFSR_DW +: LFSR_DW]   = r_state;
    assign O_CNT[c*CNT_W +: CNT_W]        = r_cnt;
  end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
module tb_lfsr_prbs_gen;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        I_EN;
  logic [1:0]  I_SEED_LD;
  logic [7:0]  I_SEED;
  logic [1:0]  I_READY;
  logic [1:0]  o_valid,  o_valid4;
  logic [15:0] o_data,   o_data4;
  logic [31:0] o_cnt;
  logic [7:0]  o_cnt4;

  int total = 0;
  int bad   = 0;
  logic [255:0] seen;

  always #5 CLK = ~CLK;

  lfsr_prbs_gen dut (
    .CLK(CLK), .RST_N(RST_N), .I_EN(I_EN), .I_SEED_LD(I_SEED_LD), .I_SEED(I_SEED),
    .O_VALID(o_valid), .I_READY(I_READY), .O_DATA(o_data), .O_CNT(o_cnt)
  );

  lfsr_prbs_gen #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .I_EN(I_EN), .I_SEED_LD(I_SEED_LD), .I_SEED(I_SEED),
    .O_VALID(o_valid4), .I_READY(I_READY), .O_DATA(o_data4), .O_CNT(o_cnt4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step checks for the main instance: valid, both channel words, ch0 count.
  task automatic chk_main(input string tag, input logic [1:0] v, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [15:0] c0);
    chk({tag, "_valid"}, {30'd0, o_valid}, {30'd0, v});
    chk({tag, "_d0"}, {24'd0, o_data[7:0]}, {24'd0, d0});
    chk({tag, "_d1"}, {24'd0, o_data[15:8]}, {24'd0, d1});
    chk({tag, "_cnt0"}, {16'd0, o_cnt[15:0]}, {16'd0, c0});
  endtask

  initial begin
    logic [7:0] exp0 [5];
    logic [7:0] exp1 [5];
    exp0 = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    exp1 = '{8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

    // Reset, with a seed load pending to show reset wins.
    RST_N = 1'b0; I_EN = 1'b0; I_SEED_LD = 2'b11; I_SEED = 8'hA5; I_READY = 2'b00;
    tick(); I_SEED_LD = 2'b00; tick();
    chk_main("reset", 2'b00, 8'h01, 8'h02, 16'd0);
    chk("reset_cnt1", {16'd0, o_cnt[31:16]}, 32'd0);

    // Enable: first word one cycle later, then one step per cycle.
    RST_N = 1'b1; I_EN = 1'b1; I_READY = 2'b11;
    tick();
    chk_main("first", 2'b11, 8'h01, 8'h02, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_main($sformatf("seq%0d", i), 2'b11, exp0[i], exp1[i], 16'(i + 1));
    end

    // ch0 stalled: word frozen while ch1 keeps stepping.
    I_READY = 2'b10;
    tick();
    chk_main("stall1", 2'b11, 8'h23, 8'h8E, 16'd5);
    // EN dropped: ch0 stays valid, ch1 consumes and goes idle.
    I_EN = 1'b0;
    tick();
    chk_main("stall2", 2'b01, 8'h23, 8'h1C, 16'd5);
    // EN back: ch0 handshakes, ch1 re-offers its word without stepping.
    I_EN = 1'b1; I_READY = 2'b11;
    tick();
    chk_main("resume", 2'b11, 8'h47, 8'h1C, 16'd6);

    // Zero seed falls back to the default; ch1 unaffected.
    I_SEED_LD = 2'b01; I_SEED = 8'h00;
    tick();
    chk_main("seed0", 2'b11, 8'h01, 8'h38, 16'd0);
    I_SEED_LD = 2'b00;
    tick();
    chk_main("seed0_step", 2'b11, 8'h02, 8'h71, 16'd1);

    // Load wins over a same-cycle handshake.
    I_SEED_LD = 2'b01; I_SEED = 8'hA5;
    tick();
    chk_main("seed_hs", 2'b11, 8'hA5, 8'hE2, 16'd0);

    // Full period from 01.
    I_SEED = 8'h01;
    tick();
    I_SEED_LD = 2'b00;
    chk("period_start", {24'd0, o_data[7:0]}, 32'h01);
    seen = '0;
    seen[1] = 1'b1;
    for (int i = 0; i < 254; i++) begin
      tick();
      chk("period_nonzero", {31'd0, (o_data[7:0] != 8'h00)}, 32'd1);
      chk("period_unique", {31'd0, seen[o_data[7:0]]}, 32'd0);
      seen[o_data[7:0]] = 1'b1;
    end
    tick();
    chk("period_wrap", {24'd0, o_data[7:0]}, 32'h01);
    chk("period_cnt", {16'd0, o_cnt[15:0]}, 32'd255);

    // 4-bit counter wrap on the second instance.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    chk("c4_valid", {30'd0, o_valid4}, 32'd3);
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i >= 15) chk($sformatf("c4_cnt%0d", i), {28'd0, o_cnt4[3:0]}, 32'(i % 16));
    end
    chk("c4_main_cnt", {16'd0, o_cnt[15:0]}, 32'd17);
    chk("c4_d0", {24'd0, o_data4[7:0]}, {24'd0, o_data[7:0]});

    // Reset mid-stream.
    RST_N = 1'b0;
    tick();
    chk_main("midrst", 2'b00, 8'h01, 8'h02, 16'd0);
    chk("midrst_c4", {24'd0, o_cnt4}, 32'd0);
    chk("midrst_v4", {30'd0, o_valid4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
